// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, sends one odd-parity byte on the
// device-generated clock, then checks the device ACK. Both lines are open-drain.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000,
    parameter int unsigned FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_ps2,
    input  logic [7:0] din,
    inout  wire        ps2c,
    inout  wire        ps2d,
    output logic       tx_idle,
    output logic       tx_done_tick,
    output logic       tx_err,
    output logic       rx_en_o
);

    typedef enum logic [2:0] {
        StIdle,
        StRts,
        StStart,
        StData,
        StStop,
        StWait
    } state_e;

    localparam logic [19:0] InhLast = 20'(INHIBIT_CYCLES - 1);
    localparam logic [19:0] TmoLim  = 20'(TIMEOUT_CYCLES);

    state_e                  state_q, state_d;
    logic [8:0]              pkt_q, pkt_d;
    logic [3:0]              n_q, n_d;
    logic                    bit_q, bit_d;
    logic [19:0]             cnt_q, cnt_d;
    logic                    ack_q, ack_d;
    logic                    err_q, err_d;
    logic                    done_q, done_d;
    logic                    c_oe_q, c_oe_d;
    logic                    d_oe_q, d_oe_d;
    logic [FILTER_LEN-1:0]   filt_q, filt_d;
    logic                    fc_q, fc_d;
    logic [1:0]              dsync_q, dsync_d;
    logic                    ps2d_s;
    logic                    fall;

    // Open-drain: only ever pull low or release.
    assign ps2c = c_oe_q ? 1'b0 : 1'bz;
    assign ps2d = d_oe_q ? 1'b0 : 1'bz;

    always_comb begin
        filt_d  = {filt_q[FILTER_LEN-2:0], ps2c};
        fc_d    = fc_q;
        if (&filt_q) begin
            fc_d = 1'b1;
        end else if (~|filt_q) begin
            fc_d = 1'b0;
        end
        fall    = fc_q & ~fc_d;
        dsync_d = {dsync_q[0], ps2d};
        ps2d_s  = dsync_q[1];
    end

    always_comb begin
        state_d = state_q;
        pkt_d   = pkt_q;
        n_d     = n_q;
        bit_d   = bit_q;
        cnt_d   = cnt_q;
        ack_d   = ack_q;
        err_d   = err_q;
        done_d  = 1'b0;

        case (state_q)
            StIdle: begin
                if (wr_ps2) begin
                    pkt_d   = {~^din, din};
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = StRts;
                end
            end
            StRts: begin
                if (cnt_q == InhLast) begin
                    cnt_d   = '0;
                    bit_d   = 1'b0;
                    state_d = StStart;
                end else begin
                    cnt_d = cnt_q + 20'd1;
                end
            end
            StStart: begin
                if (fall) begin
                    bit_d   = pkt_q[0];
                    n_d     = 4'd8;
                    state_d = StData;
                end
            end
            StData: begin
                if (fall) begin
                    if (n_q == 4'd0) begin
                        bit_d   = 1'b1;
                        state_d = StStop;
                    end else begin
                        pkt_d = {1'b0, pkt_q[8:1]};
                        bit_d = pkt_q[1];
                        n_d   = n_q - 4'd1;
                    end
                end
            end
            StStop: begin
                if (fall) begin
                    ack_d   = ~ps2d_s;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (fc_q && ps2d_s) begin
                    done_d  = 1'b1;
                    err_d   = ~ack_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Device watchdog: restarted by every device clock fall, overrides normal progress.
        if (state_q inside {StStart, StData, StStop, StWait}) begin
            if (fall) begin
                cnt_d = '0;
            end else if (cnt_q == TmoLim) begin
                bit_d   = 1'b1;
                done_d  = 1'b1;
                err_d   = 1'b1;
                state_d = StIdle;
            end else begin
                cnt_d = cnt_q + 20'd1;
            end
        end

        // Enables follow the current state, so they lag a state change by one cycle.
        c_oe_d = (state_q == StRts);
        d_oe_d = (state_q inside {StStart, StData}) && !bit_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            pkt_q   <= '0;
            n_q     <= '0;
            bit_q   <= 1'b1;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            c_oe_q  <= 1'b0;
            d_oe_q  <= 1'b0;
            filt_q  <= '1;
            fc_q    <= 1'b1;
            dsync_q <= 2'b11;
        end else begin
            state_q <= state_d;
            pkt_q   <= pkt_d;
            n_q     <= n_d;
            bit_q   <= bit_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            done_q  <= done_d;
            c_oe_q  <= c_oe_d;
            d_oe_q  <= d_oe_d;
            filt_q  <= filt_d;
            fc_q    <= fc_d;
            dsync_q <= dsync_d;
        end
    end

    assign tx_idle      = (state_q == StIdle);
    assign rx_en_o      = (state_q == StIdle);
    assign tx_done_tick = done_q;
    assign tx_err       = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: pulled-up open-drain bus and a behavioural keyboard that clocks
// the frame, reads the bits, and optionally ACKs, NACKs, glitches or stays silent.
module tb_ps2_host_tx;

    localparam int unsigned INH = 20;
    localparam int unsigned TMO = 200;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_ps2;
    logic [7:0] din;
    wire        ps2c;
    wire        ps2d;
    logic       tx_idle;
    logic       tx_done_tick;
    logic       tx_err;
    logic       rx_en_o;
    logic       dev_c;
    logic       dev_d;

    int total = 0;
    int bad   = 0;

    assign ps2c = dev_c ? 1'b0 : 1'bz;
    assign ps2d = dev_d ? 1'b0 : 1'bz;
    pullup (ps2c);
    pullup (ps2d);

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO),
        .FILTER_LEN    (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_ps2      (wr_ps2),
        .din         (din),
        .ps2c        (ps2c),
        .ps2d        (ps2d),
        .tx_idle     (tx_idle),
        .tx_done_tick(tx_done_tick),
        .tx_err      (tx_err),
        .rx_en_o     (rx_en_o)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_c(input logic val, input int lim, input string tag);
        int k;
        k = 0;
        while (ps2c !== val && k < lim) begin
            @(negedge clk);
            k++;
        end
        check_eq(tag, 32'(ps2c), 32'(val));
    endtask

    task automatic start_wr(input logic [7:0] b);
        @(negedge clk);
        din    = b;
        wr_ps2 = 1'b1;
        @(negedge clk);
        wr_ps2 = 1'b0;
        check_eq("busy_after_wr", 32'(tx_idle), 32'd0);
        check_eq("err_cleared", 32'(tx_err), 32'd0);
    endtask

    task automatic check_released(input string tag);
        repeat (2) @(negedge clk);
        check_eq({tag, "_c"}, 32'(ps2c), 32'd1);
        check_eq({tag, "_d"}, 32'(ps2d), 32'd1);
        check_eq({tag, "_idle"}, 32'(tx_idle), 32'd1);
        check_eq({tag, "_rxen"}, 32'(rx_en_o), 32'd1);
    endtask

    // One frame from the keyboard's point of view; reference bits come from plain arithmetic.
    task automatic xfer(input logic [7:0] b, input bit nack, input bit glitch,
                        input bit second_wr, input bit rst_mid);
        logic [9:0] got;
        int         lo;
        int         half;
        int         ones;
        int         k;
        bit         rx_bad;
        logic       exp_par;

        half   = int'($urandom_range(40, 20));
        rx_bad = 1'b0;
        got    = '0;
        start_wr(b);
        wait_c(1'b0, 10, "rts_begin");
        lo = 0;
        while (ps2c === 1'b0 && lo < 4 * INH) begin
            @(negedge clk);
            lo++;
        end
        check_eq("rts_len", 32'(lo), 32'(INH));
        check_eq("start_bit", 32'(ps2d), 32'd0);

        for (int i = 0; i < 11; i++) begin
            repeat (half / 2) @(negedge clk);
            if (glitch && i == 4) begin
                dev_c = 1'b1;
                repeat (3) @(negedge clk);
                dev_c = 1'b0;
            end
            if (second_wr && i == 2) begin
                din    = 8'h55;
                wr_ps2 = 1'b1;
                @(negedge clk);
                wr_ps2 = 1'b0;
            end
            repeat (half / 2) @(negedge clk);
            if (i == 10 && !nack) begin
                dev_d = 1'b1;
                repeat (5) @(negedge clk);
            end
            dev_c = 1'b1;
            repeat (half) @(negedge clk);
            if (rx_en_o !== 1'b0) rx_bad = 1'b1;
            dev_c = 1'b0;
            if (i < 10) got[i] = ps2d;
            if (rst_mid && i == 3) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                check_eq("rst_c", 32'(ps2c), 32'd1);
                check_eq("rst_d", 32'(ps2d), 32'd1);
                check_eq("rst_idle", 32'(tx_idle), 32'd1);
                k = 0;
                for (int j = 0; j < 100; j++) begin
                    @(negedge clk);
                    if (tx_done_tick === 1'b1) k++;
                end
                check_eq("rst_no_done", 32'(k), 32'd0);
                return;
            end
        end
        repeat (5) @(negedge clk);
        dev_d = 1'b0;

        k = 0;
        while (tx_done_tick !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check_eq("done", 32'(tx_done_tick), 32'd1);
        check_eq("err", 32'(tx_err), 32'(nack));
        @(negedge clk);
        check_eq("done_width", 32'(tx_done_tick), 32'd0);
        check_released("post");

        ones = 0;
        for (int j = 0; j < 8; j++) ones += int'((b >> j) & 8'd1);
        exp_par = (ones % 2 == 0);
        check_eq("data_bits", 32'(got[7:0]), 32'(b));
        check_eq("parity", 32'(got[8]), 32'(exp_par));
        check_eq("stop_bit", 32'(got[9]), 32'd1);
        check_eq("rx_en_frame", 32'(rx_bad), 32'd0);
    endtask

    task automatic timeout_run();
        int k;
        start_wr(8'hFF);
        wait_c(1'b0, 10, "tmo_rts");
        wait_c(1'b1, 4 * INH, "tmo_release");
        k = 0;
        while (tx_done_tick !== 1'b1 && k < 2 * TMO) begin
            @(negedge clk);
            k++;
        end
        check_eq("tmo_len", 32'(k), 32'(TMO));
        check_eq("tmo_err", 32'(tx_err), 32'd1);
        check_released("tmo");
    endtask

    initial begin
        reset  = 1'b1;
        wr_ps2 = 1'b0;
        din    = 8'h00;
        dev_c  = 1'b0;
        dev_d  = 1'b0;
        repeat (3) @(negedge clk);
        // wr_ps2 coincident with reset must be dropped.
        wr_ps2 = 1'b1;
        @(negedge clk);
        wr_ps2 = 1'b0;
        reset  = 1'b0;
        check_eq("rst_idle0", 32'(tx_idle), 32'd1);
        check_eq("rst_done0", 32'(tx_done_tick), 32'd0);
        check_eq("rst_err0", 32'(tx_err), 32'd0);
        check_eq("rst_rxen0", 32'(rx_en_o), 32'd1);
        check_released("rst0");

        xfer(8'hED, 1'b0, 1'b0, 1'b0, 1'b0);
        xfer(8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
        xfer(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
        xfer(8'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        check_eq("err_held", 32'(tx_err), 32'd1);
        timeout_run();
        xfer(8'($urandom), 1'b0, 1'b0, 1'b0, 1'b1);
        xfer(8'hF4, 1'b0, 1'b0, 1'b0, 1'b0);
        xfer(8'($urandom), 1'b0, 1'b1, 1'b1, 1'b0);
        for (int r = 0; r < 4; r++) begin
            xfer(8'($urandom), bit'($urandom_range(1, 0)), 1'b0, 1'b0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
